nn_train_sequencer: RTL and testbench

- Epoch/sample scheduler for the neural-network core; the "Control" block that drives the pattern store's TR/VL/SW/START/END strobes.
- Each epoch runs TRAIN training samples, then VALID validation samples, through the architecture.
- Counts validation misclassifications and pulses SW when an epoch beats the best error seen so far, so the pattern store snapshots the best weights.
- Pulses END after EPOCH epochs.

---
 rtl/nn_pkg.sv | 19 +
 rtl/nn_err_tracker.sv | 38 +++
 rtl/nn_train_sequencer.sv | 116 +++++++++++
 tb/tb_nn_train_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared state encoding and constants for the training sequencer
package nn_pkg;
    localparam int NN_BITS = 16;
    localparam logic [NN_BITS-1:0] ERR_INIT = '1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_T_FETCH,
        S_T_GO,
        S_T_WAIT,
        S_V_FETCH,
        S_V_GO,
        S_V_WAIT,
        S_EVAL,
        S_STORE,
        S_FIN
    } seq_state_t;
endpackage

// File: rtl/nn_err_tracker.sv
// rtl/nn_err_tracker.sv - saturating validation error count and best-error record
module nn_err_tracker
    import nn_pkg::*;
#(
    parameter int BITS = NN_BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear_run,
    input  logic            clear_val,
    input  logic            err_inc,
    input  logic            update_best,
    output logic            improve,
    output logic [BITS-1:0] best_err
);
    localparam logic [BITS-1:0] ALL_ONES = {BITS{ERR_INIT[0]}};

    logic [BITS-1:0] val_err;

    always_ff @(posedge clk) begin
        if (!rst_n || clear_run) begin
            val_err  <= '0;
            best_err <= ALL_ONES;
        end else begin
            if (update_best) begin
                best_err <= val_err;
            end
            // update_best and clear_val can coincide in EVAL; best_err takes the pre-clear count
            if (clear_val) begin
                val_err <= '0;
            end else if (err_inc && val_err != ALL_ONES) begin
                val_err <= val_err + BITS'(1);
            end
        end
    end

    assign improve = val_err < best_err;
endmodule

// File: rtl/nn_train_sequencer.sv
// rtl/nn_train_sequencer.sv - epoch/sample scheduler driving pattern-store strobes
module nn_train_sequencer
    import nn_pkg::*;
#(
    parameter int BITS = NN_BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            go,
    input  logic [BITS-1:0] TRAIN,
    input  logic [BITS-1:0] VALID,
    input  logic [BITS-1:0] EPOCH,
    input  logic            nn_done,
    input  logic            nn_err,
    output logic            START,
    output logic            TR,
    output logic            VL,
    output logic            SW,
    output logic            END,
    output logic            nn_go,
    output logic            nn_train,
    output logic            busy,
    output logic [BITS-1:0] epoch_cnt,
    output logic [BITS-1:0] best_err
);
    seq_state_t      state, nxt;
    logic [BITS-1:0] sample_cnt;
    logic [BITS-1:0] cnt_inc, epoch_inc;
    logic            improve;
    logic            has_train, has_valid;
    seq_state_t      epoch_entry;

    assign cnt_inc     = sample_cnt + BITS'(1);
    assign epoch_inc   = epoch_cnt + BITS'(1);
    assign has_train   = TRAIN != '0;
    assign has_valid   = VALID != '0;
    assign epoch_entry = has_train ? S_T_FETCH : (has_valid ? S_V_FETCH : S_EVAL);

    nn_err_tracker #(.BITS(BITS)) u_err (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_run  (state == S_INIT),
        .clear_val  (state == S_EVAL || state == S_STORE),
        .err_inc    (state == S_V_WAIT && nn_done && nn_err),
        .update_best(state == S_EVAL && has_valid && improve),
        .improve    (improve),
        .best_err   (best_err)
    );

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    if (go) nxt = S_INIT;
            S_INIT:    nxt = (EPOCH == '0) ? S_FIN : epoch_entry;
            S_T_FETCH: nxt = S_T_GO;
            S_T_GO:    nxt = S_T_WAIT;
            S_T_WAIT:
                if (nn_done) begin
                    if (cnt_inc == TRAIN) nxt = has_valid ? S_V_FETCH : S_EVAL;
                    else                  nxt = S_T_FETCH;
                end
            S_V_FETCH: nxt = S_V_GO;
            S_V_GO:    nxt = S_V_WAIT;
            S_V_WAIT:
                if (nn_done) nxt = (cnt_inc == VALID) ? S_EVAL : S_V_FETCH;
            // EVAL compares the incremented epoch count, STORE the already-updated one
            S_EVAL:
                if (has_valid && improve)      nxt = S_STORE;
                else if (epoch_inc == EPOCH)   nxt = S_FIN;
                else                           nxt = epoch_entry;
            S_STORE:   nxt = (epoch_cnt == EPOCH) ? S_FIN : epoch_entry;
            S_FIN:     nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            START      <= 1'b0;
            TR         <= 1'b0;
            VL         <= 1'b0;
            SW         <= 1'b0;
            END        <= 1'b0;
            nn_go      <= 1'b0;
            nn_train   <= 1'b0;
            busy       <= 1'b0;
            sample_cnt <= '0;
            epoch_cnt  <= '0;
        end else begin
            state    <= nxt;
            START    <= nxt == S_INIT;
            TR       <= nxt == S_T_FETCH;
            VL       <= nxt == S_V_FETCH;
            SW       <= nxt == S_STORE;
            END      <= nxt == S_FIN;
            nn_go    <= nxt == S_T_GO || nxt == S_V_GO;
            nn_train <= nxt == S_T_GO || nxt == S_T_WAIT;
            busy     <= nxt != S_IDLE;
            case (state)
                S_INIT: begin
                    sample_cnt <= '0;
                    epoch_cnt  <= '0;
                end
                S_T_WAIT: if (nn_done) sample_cnt <= (cnt_inc == TRAIN) ? '0 : cnt_inc;
                S_V_WAIT: if (nn_done) sample_cnt <= (cnt_inc == VALID) ? '0 : cnt_inc;
                S_EVAL: begin
                    epoch_cnt  <= epoch_inc;
                    sample_cnt <= '0;
                end
                S_STORE:  sample_cnt <= '0;
                default:  ;
            endcase
        end
    end
endmodule

// File: tb/tb_nn_train_sequencer.sv
// tb/tb_nn_train_sequencer.sv - scoreboard bench with randomized runs and a behavioural epoch model
module tb_nn_train_sequencer;
    localparam int BITS = 16;
    localparam int K_START = 0, K_TR = 1, K_VL = 2, K_SW = 3, K_END = 4;

    logic clk = 1'b0, rst_n = 1'b0, go = 1'b0, go_spur = 1'b0;
    logic nn_done = 1'b0, nn_err = 1'b0;
    logic [BITS-1:0] TRAIN = '0, VALID = '0, EPOCH = '0;
    logic START, TR, VL, SW, END, nn_go, nn_train, busy;
    logic [BITS-1:0] epoch_cnt, best_err;

    always #5 clk = ~clk;

    nn_train_sequencer #(.BITS(BITS)) dut (
        .clk(clk), .rst_n(rst_n), .go(go | go_spur),
        .TRAIN(TRAIN), .VALID(VALID), .EPOCH(EPOCH),
        .nn_done(nn_done), .nn_err(nn_err),
        .START(START), .TR(TR), .VL(VL), .SW(SW), .END(END),
        .nn_go(nn_go), .nn_train(nn_train), .busy(busy),
        .epoch_cnt(epoch_cnt), .best_err(best_err)
    );

    typedef struct {
        int kind;
        int ep;
        int best;
    } ev_t;

    ev_t q[$];
    int  checks = 0, errors = 0;
    bit  err_flat[64];
    int  cyc = 0, end_seen = 0, start_cyc = 0, end_cyc = 0;
    bit  prev_tr = 0, prev_vl = 0;
    int  mkind;
    ev_t mev;
    int  pend = 0, vidx = 0;
    bit  is_tr = 0, spur_go = 0, force_done = 0, go_spur_en = 0;

    function automatic ev_t ev(input int kind, input int ep, input int best);
        ev_t e;
        e.kind = kind;
        e.ep   = ep;
        e.best = best;
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every strobe is popped from the scoreboard and compared
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (START | TR | VL | SW | END) begin
                chk("onehot", $countones({START, TR, VL, SW, END}), 1);
                mkind = START ? K_START : TR ? K_TR : VL ? K_VL : SW ? K_SW : K_END;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got kind %0d expected none", mkind);
                end else begin
                    mev = q.pop_front();
                    chk("strobe_kind", mkind, mev.kind);
                    if (mkind == K_END) begin
                        chk("end_epoch_cnt", epoch_cnt, mev.ep);
                        chk("end_best_err", best_err, mev.best);
                    end
                end
                if (START) start_cyc = cyc;
                if (END) begin
                    end_cyc = cyc;
                    end_seen++;
                end
            end
            if (nn_go) begin
                chk("go_after_fetch", prev_tr | prev_vl, 1);
                chk("nn_train_on_go", nn_train, prev_tr);
            end
            prev_tr = TR;
            prev_vl = VL;
        end
    end

    // Architecture stand-in: answers each nn_go after 1..3 cycles
    always @(negedge clk) begin
        nn_done = force_done;
        nn_err  = 1'b0;
        go_spur = 1'b0;
        if (START) vidx = 0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                nn_done = 1'b1;
                if (!is_tr) begin
                    nn_err = err_flat[vidx % 64];
                    vidx++;
                end
            end
        end
        if (nn_go) begin
            pend  = $urandom_range(1, 3);
            is_tr = nn_train;
            if (spur_go) nn_done = 1'b1;
        end
        if (go_spur_en && nn_train && !nn_go) go_spur = 1'b1;
    end

    task automatic model_push(input int tr, input int va, input int ep);
        int best = 65535;
        int idx = 0;
        int err;
        q.push_back(ev(K_START, 0, 0));
        for (int e = 0; e < ep; e++) begin
            for (int t = 0; t < tr; t++) q.push_back(ev(K_TR, 0, 0));
            err = 0;
            for (int v = 0; v < va; v++) begin
                q.push_back(ev(K_VL, 0, 0));
                err += int'(err_flat[idx]);
                idx++;
            end
            if (va > 0 && err < best) begin
                best = err;
                q.push_back(ev(K_SW, 0, 0));
            end
        end
        q.push_back(ev(K_END, ep, best));
    endtask

    task automatic launch(input int tr, input int va, input int ep);
        TRAIN = BITS'(tr);
        VALID = BITS'(va);
        EPOCH = BITS'(ep);
        model_push(tr, va, ep);
        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
    endtask

    task automatic run_test(input int tr, input int va, input int ep);
        int n0, w;
        n0 = end_seen;
        launch(tr, va, ep);
        w = 0;
        while (end_seen == n0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk("run_completed", end_seen - n0, 1);
        @(negedge clk);
        @(negedge clk);
        chk("busy_after_end", busy, 0);
        chk("queue_drained", q.size(), 0);
        if (ep == 0) chk("start_end_gap", end_cyc - start_cyc, 1);
        q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_strobes"}, {START, TR, VL, SW, END, nn_go, nn_train, busy}, 0);
        chk({tag, "_epoch_cnt"}, epoch_cnt, 0);
        chk({tag, "_best_err"}, best_err, 16'hFFFF);
    endtask

    initial begin
        int nvl, w;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        foreach (err_flat[i]) err_flat[i] = 1'b0;
        run_test(3, 2, 1);

        foreach (err_flat[i]) err_flat[i] = 1'b0;
        err_flat[0] = 1; err_flat[1] = 1; err_flat[2] = 1;
        err_flat[4] = 1;
        err_flat[8] = 1; err_flat[9] = 1;
        run_test(2, 4, 3);

        run_test(3, 2, 0);
        run_test(2, 0, 2);

        // Reset during V_WAIT of the second epoch
        foreach (err_flat[i]) err_flat[i] = 1'($urandom_range(0, 1));
        launch(2, 3, 3);
        nvl = 0;
        w = 0;
        while (nvl < 4 && w < 2000) begin
            @(negedge clk);
            if (VL) nvl++;
            w++;
        end
        chk("reach_epoch2_vl", nvl, 4);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        check_idle_outputs("midrun_reset");
        force_done = 1'b1;
        @(negedge clk) force_done = 1'b0;
        repeat (6) @(negedge clk);
        chk("idle_after_late_done", busy, 0);
        run_test(2, 3, 2);

        // Spurious nn_done in IDLE and T_GO, go during waits
        force_done = 1'b1;
        repeat (2) @(negedge clk);
        force_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_spurious_done", busy, 0);
        spur_go = 1'b1;
        go_spur_en = 1'b1;
        run_test(2, 2, 2);
        spur_go = 1'b0;
        go_spur_en = 1'b0;

        for (int r = 0; r < 10; r++) begin
            foreach (err_flat[i]) err_flat[i] = 1'($urandom_range(0, 1));
            run_test($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
